// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array drain path.
//
// Contents:
//   ARRAY_DIM         number of array columns (one psum per column per row)
//   ACC_W             accumulator / psum width
//   DRAIN_FIFO_DEPTH  output row FIFO depth (power of two)
//   ROW_CNT_W         width of the per-job row counter and cfg_rows
//   drain_state_e     drain controller state encoding
//   fifo_entry_t      one FIFO entry: aligned row plus its last flag
//   is_last_row()     true when a row index is the final row of a job
package systolic_pkg;

    localparam int ARRAY_DIM        = 16;
    localparam int ACC_W            = 32;
    localparam int DRAIN_FIFO_DEPTH = 4;
    localparam int ROW_CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_e;

    typedef struct packed {
        logic                                last;
        logic [ARRAY_DIM-1:0][ACC_W-1:0]     data;
    } fifo_entry_t;

    // Row indices run 0..rows-1; only called with rows != 0.
    function automatic logic is_last_row(input logic [ROW_CNT_W-1:0] cnt,
                                         input logic [ROW_CNT_W-1:0] rows);
        return cnt == (rows - ROW_CNT_W'(1));
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO holding aligned result rows for the consumer.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO,
//                clears storage so the head reads as zero)
//   push         write push_entry when accepted
//   push_entry   row data plus last flag
//   pop          remove the head entry (ignored when empty)
//   head         current head entry; only changes on pop or on a push
//                into an empty FIFO
//   empty, full  occupancy flags
//
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; the freed slot is the one being written.
module drain_fifo
    import systolic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        empty,
    output logic        full
);

    localparam int PTR_W = $clog2(DRAIN_FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DRAIN_FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    fifo_entry_t      mem [DRAIN_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DRAIN_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Drain path for the bottom row of a systolic array.
//
// The array delivers one psum per column per row, with column j arriving
// j cycles after column 0. This block deskews the columns back into whole
// rows, counts rows against a job length, tags the final row, and buffers
// rows in a 4-entry FIFO for the consumer.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sys_output      per-column psums from the array bottom row
//   sys_valid_out   per-column valids (column j lags column 0 by j cycles)
//   start           begin a job; honoured only in IDLE
//   cfg_rows        rows in the job, sampled on an accepted start
//   out_ready       consumer ready
//   out_data        aligned result row at the FIFO head
//   out_valid       FIFO non-empty
//   out_last        head row is the final row of the job
//   busy            controller not in IDLE
//   done            one-cycle pulse when the job has fully drained
//   overflow        sticky: a row was dropped because the FIFO was full
//   skew_err        sticky: deskewed column valids disagreed
//   dbg_state       current controller state
//
// Output handshake: a row transfers in any cycle where out_valid and
// out_ready are both high. Once out_valid is high it stays high, and
// out_data/out_last stay unchanged, until that transfer happens;
// out_valid never depends combinationally on out_ready or on the inputs.
module systolic_drain
    import systolic_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ARRAY_DIM-1:0][ACC_W-1:0]   sys_output,
    input  logic [ARRAY_DIM-1:0]              sys_valid_out,
    input  logic                              start,
    input  logic [ROW_CNT_W-1:0]              cfg_rows,
    input  logic                              out_ready,
    output logic [ARRAY_DIM-1:0][ACC_W-1:0]   out_data,
    output logic                              out_valid,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow,
    output logic                              skew_err,
    output drain_state_e                      dbg_state
);

    // ------------------------------------------------------------------
    // Deskew: column j gets ARRAY_DIM-1-j register stages so that every
    // column of a row lines up with column 0. The last column passes
    // straight through.
    // ------------------------------------------------------------------
    logic [ARRAY_DIM-1:0][ACC_W-1:0] al_data;
    logic [ARRAY_DIM-1:0]            al_valid;

    for (genvar j = 0; j < ARRAY_DIM; j++) begin : g_col
        localparam int STAGES = ARRAY_DIM - 1 - j;
        if (STAGES == 0) begin : g_pass
            assign al_data[j]  = sys_output[j];
            assign al_valid[j] = sys_valid_out[j];
        end else begin : g_dly
            logic [ACC_W-1:0]  d_sr [STAGES];
            logic [STAGES-1:0] v_sr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_sr <= '0;
                    for (int k = 0; k < STAGES; k++) begin
                        d_sr[k] <= '0;
                    end
                end else begin
                    d_sr[0] <= sys_output[j];
                    v_sr[0] <= sys_valid_out[j];
                    for (int k = 1; k < STAGES; k++) begin
                        d_sr[k] <= d_sr[k-1];
                        v_sr[k] <= v_sr[k-1];
                    end
                end
            end

            assign al_data[j]  = d_sr[STAGES-1];
            assign al_valid[j] = v_sr[STAGES-1];
        end
    end

    // Column 0 defines the row; any other column disagreeing means the
    // upstream skew was not the expected one-cycle-per-column staircase.
    logic row_valid;
    logic skew_mismatch;

    assign row_valid     = al_valid[0];
    assign skew_mismatch = |(al_valid ^ {ARRAY_DIM{al_valid[0]}});

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    drain_state_e           state;
    logic [ROW_CNT_W-1:0]   cfg_q;
    logic [ROW_CNT_W-1:0]   row_cnt;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push_req;
    logic        pop;
    logic        row_last;
    logic        push_drop;

    assign row_last        = is_last_row(row_cnt, cfg_q);
    assign push_req        = (state == ST_RUN) && row_valid;
    assign push_entry.last = row_last;
    assign push_entry.data = al_data;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = head.data;
    assign out_last  = head.last;

    // A pop in the same cycle frees a slot, so only a full FIFO with no
    // pop loses the row.
    assign push_drop = push_req && fifo_full && !pop;

    drain_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_req),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // ------------------------------------------------------------------
    // Job FSM. Dropped rows still advance row_cnt so the job always ends
    // after cfg_rows aligned rows, whether or not they were stored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cfg_q    <= '0;
            row_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            skew_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg_q    <= cfg_rows;
                        row_cnt  <= '0;
                        overflow <= 1'b0;
                        skew_err <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (cfg_rows == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (skew_mismatch) begin
                        skew_err <= 1'b1;
                    end
                    if (row_valid) begin
                        row_cnt <= row_cnt + ROW_CNT_W'(1);
                        if (push_drop) begin
                            overflow <= 1'b1;
                        end
                        if (row_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (skew_mismatch) begin
                        skew_err <= 1'b1;
                    end
                    if (fifo_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;
    import systolic_pkg::*;

    localparam int W = ARRAY_DIM * ACC_W + 1;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ARRAY_DIM-1:0][ACC_W-1:0] sys_output = '0;
    logic [ARRAY_DIM-1:0]            sys_valid_out = '0;
    logic                            start = 1'b0;
    logic [ROW_CNT_W-1:0]            cfg_rows = '0;
    logic                            out_ready = 1'b0;
    logic [ARRAY_DIM-1:0][ACC_W-1:0] out_data;
    logic                            out_valid;
    logic                            out_last;
    logic                            busy;
    logic                            done;
    logic                            overflow;
    logic                            skew_err;
    drain_state_e                    dbg_state;

    systolic_drain dut (
        .clk           (clk),
        .rst           (rst),
        .sys_output    (sys_output),
        .sys_valid_out (sys_valid_out),
        .start         (start),
        .cfg_rows      (cfg_rows),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .skew_err      (skew_err),
        .dbg_state     (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           t0 = 0;
    logic         seen_ov = 1'b0;
    int           first_ov_cyc = 0;

    function automatic logic [W-1:0] bw(input logic x);
        return {{(W-1){1'b0}}, x};
    endfunction

    function automatic logic [W-1:0] iw(input int x);
        return W'(x);
    endfunction

    // Expected row r of a job: column j carries base + 100*row + j, where
    // column 7 may lag by extra7 rows (zero before its first row arrives).
    function automatic logic [W-1:0] exp_row(input int base, input int r,
                                             input int extra7, input logic last);
        logic [ARRAY_DIM-1:0][ACC_W-1:0] d;
        int rr;
        for (int j = 0; j < ARRAY_DIM; j++) begin
            rr   = r - ((j == 7) ? extra7 : 0);
            d[j] = (rr >= 0) ? ACC_W'(base + 100 * rr + j) : '0;
        end
        return {last, d};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: scoreboard the head row if it transfers this cycle, then
    // advance to 1 time unit after the next rising edge.
    task automatic tick();
        logic [W-1:0] e;
        if (out_valid === 1'b1 && !seen_ov) begin
            seen_ov      = 1'b1;
            first_ov_cyc = cyc;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("row_expected", bw(exp_q.size() != 0), bw(1'b1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("row", {out_last, out_data}, e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive n rows in the array's staircase pattern. pulse_c >= 0 raises
    // out_ready for that one feed cycle; ncyc > 0 cuts the feed short.
    task automatic feed(input int n, input int base, input int extra7,
                        input int pulse_c, input int ncyc);
        int   total;
        int   rr;
        logic keep_ready;
        total      = (ncyc > 0) ? ncyc : n + ARRAY_DIM - 1 + extra7;
        keep_ready = out_ready;
        for (int c = 0; c < total; c++) begin
            if (c == 0) t0 = cyc;
            for (int j = 0; j < ARRAY_DIM; j++) begin
                rr = c - j - ((j == 7) ? extra7 : 0);
                if (rr >= 0 && rr < n) begin
                    sys_valid_out[j] = 1'b1;
                    sys_output[j]    = ACC_W'(base + 100 * rr + j);
                end else begin
                    sys_valid_out[j] = 1'b0;
                    sys_output[j]    = '0;
                end
            end
            out_ready = (c == pulse_c) ? 1'b1 : keep_ready;
            tick();
        end
        sys_valid_out = '0;
        sys_output    = '0;
        out_ready     = keep_ready;
    endtask

    task automatic wait_done(input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic start_job(input int rows);
        cfg_rows = ROW_CNT_W'(rows);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int   base;
        logic got;
        int   stale;
        int   dn;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", bw(out_valid), bw(1'b0));
        check("rst_out_last",  bw(out_last),  bw(1'b0));
        check("rst_busy",      bw(busy),      bw(1'b0));
        check("rst_done",      bw(done),      bw(1'b0));
        check("rst_overflow",  bw(overflow),  bw(1'b0));
        check("rst_skew_err",  bw(skew_err),  bw(1'b0));
        check("rst_out_data",  {1'b0, out_data}, iw(0));
        check("rst_state",     iw(int'(dbg_state)), iw(int'(ST_IDLE)));

        // Three rows, consumer always ready
        out_ready = 1'b1;
        start_job(3);
        check("t1_busy", bw(busy), bw(1'b1));
        base = int'($urandom_range(1, 999)) * 1000;
        for (int r = 0; r < 3; r++) exp_q.push_back(exp_row(base, r, 0, r == 2));
        seen_ov = 1'b0;
        feed(3, base, 0, -1, 0);
        wait_done(40, got);
        check("t1_done_seen", bw(got), bw(1'b1));
        check("t1_latency", iw(first_ov_cyc - t0), iw(16));
        check("t1_busy_low", bw(busy), bw(1'b0));
        tick();
        check("t1_done_pulse", bw(done), bw(1'b0));
        check("t1_queue_empty", iw(exp_q.size()), iw(0));

        // Six rows into a stalled consumer: four held, two dropped
        out_ready = 1'b0;
        start_job(6);
        base = int'($urandom_range(1, 999)) * 1000;
        for (int r = 0; r < 4; r++) exp_q.push_back(exp_row(base, r, 0, 1'b0));
        feed(6, base, 0, -1, 0);
        check("t2_overflow", bw(overflow), bw(1'b1));
        check("t2_out_valid", bw(out_valid), bw(1'b1));
        check("t2_state", iw(int'(dbg_state)), iw(int'(ST_DRAIN)));
        check("t2_hold_a", {out_last, out_data}, exp_row(base, 0, 0, 1'b0));
        repeat (3) tick();
        check("t2_hold_b", {out_last, out_data}, exp_row(base, 0, 0, 1'b0));
        check("t2_no_done", bw(done), bw(1'b0));
        out_ready = 1'b1;
        wait_done(20, got);
        check("t2_done_seen", bw(got), bw(1'b1));
        check("t2_queue_empty", iw(exp_q.size()), iw(0));
        check("t2_overflow_sticky", bw(overflow), bw(1'b1));
        tick();

        // Full FIFO with push and pop in the same cycle
        out_ready = 1'b0;
        start_job(5);
        check("t3_overflow_cleared", bw(overflow), bw(1'b0));
        base = int'($urandom_range(1, 999)) * 1000;
        for (int r = 0; r < 5; r++) exp_q.push_back(exp_row(base, r, 0, r == 4));
        feed(5, base, 0, 19, 0);
        check("t3_overflow", bw(overflow), bw(1'b0));
        check("t3_out_valid", bw(out_valid), bw(1'b1));
        out_ready = 1'b1;
        wait_done(20, got);
        check("t3_done_seen", bw(got), bw(1'b1));
        check("t3_queue_empty", iw(exp_q.size()), iw(0));
        tick();

        // Column 7 one cycle late
        out_ready = 1'b1;
        start_job(2);
        base = int'($urandom_range(1, 999)) * 1000;
        exp_q.push_back(exp_row(base, 0, 1, 1'b0));
        exp_q.push_back(exp_row(base, 1, 1, 1'b1));
        feed(2, base, 1, -1, 0);
        wait_done(20, got);
        check("t4_done_seen", bw(got), bw(1'b1));
        check("t4_skew_err", bw(skew_err), bw(1'b1));
        repeat (2) tick();
        check("t4_skew_sticky", bw(skew_err), bw(1'b1));
        check("t4_queue_empty", iw(exp_q.size()), iw(0));

        // Zero-row job, plus a start while busy
        start_job(0);
        check("t5_busy", bw(busy), bw(1'b1));
        check("t5_state", iw(int'(dbg_state)), iw(int'(ST_DRAIN)));
        check("t5_skew_cleared", bw(skew_err), bw(1'b0));
        cfg_rows = 8'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("t5_done", bw(done), bw(1'b1));
        check("t5_busy_low", bw(busy), bw(1'b0));
        check("t5_out_valid", bw(out_valid), bw(1'b0));
        tick();
        check("t5_done_pulse", bw(done), bw(1'b0));
        check("t5_start_ignored", iw(int'(dbg_state)), iw(int'(ST_IDLE)));

        // Reset mid-job with rows in the FIFO and in the deskew
        out_ready = 1'b0;
        start_job(5);
        base = int'($urandom_range(1, 999)) * 1000;
        feed(3, base, 0, -1, 17);
        check("t6_pre_rst_valid", bw(out_valid), bw(1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_out_valid", bw(out_valid), bw(1'b0));
        check("t6_busy", bw(busy), bw(1'b0));
        check("t6_done", bw(done), bw(1'b0));
        check("t6_state", iw(int'(dbg_state)), iw(int'(ST_IDLE)));
        out_ready = 1'b1;
        stale = 0;
        dn    = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid === 1'b1) stale++;
            if (done === 1'b1) dn++;
            tick();
        end
        check("t6_no_stale", iw(stale), iw(0));
        check("t6_no_done", iw(dn), iw(0));
        check("t6_queue_empty", iw(exp_q.size()), iw(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
